// File: rtl/mii_rx_pkg.sv
// Shared types and constants for the MII receive frame decoder and its CRC helper.
package mii_rx_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } rx_state_e;

  localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
  localparam logic [31:0] CRC_INIT        = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY        = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE     = 32'hDEBB_20E3;
endpackage

// File: rtl/crc32_d8.sv
// Combinational Ethernet CRC-32 step: one byte, LSB first, reflected polynomial.
module crc32_d8
  import mii_rx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++) begin
      if (crc_next[0] ^ data[i]) crc_next = (crc_next >> 1) ^ CRC_POLY;
      else                       crc_next = crc_next >> 1;
    end
  end
endmodule

// File: rtl/mii_rx_frame.sv
// MII receive frame decoder: preamble/SFD strip, byte assembly, FCS/length/alignment status.
// Optional frame/CRC-error counters are built only when MII_RX_STATS_EN is defined.
module mii_rx_frame
  import mii_rx_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic        eth_rx_clk,
  input  logic        rstn,
  input  logic [3:0]  eth_rx_d,
  input  logic        eth_rx_dv,
  input  logic        eth_rx_err,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_crc_ok,
  output logic        rx_frame_err,
  output logic [10:0] rx_len,
  output logic [15:0] frame_count,
  output logic [15:0] crc_err_count
);
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_BYTES);

  rx_state_e   state, state_nxt;
  logic        phase;
  logic [3:0]  low_nib;
  logic [31:0] crc, crc_nxt;
  logic [10:0] len, len_inc;
  logic        phy_err, too_long;
  logic [7:0]  cur_byte;
  logic        sfd_hit, data_nib, eof_hit, crc_good, frame_bad;

  assign cur_byte  = {eth_rx_d, low_nib};
  assign sfd_hit   = (state == S_PREAMBLE) && eth_rx_dv && (eth_rx_d == SFD_NIBBLE);
  assign data_nib  = (state == S_DATA) && eth_rx_dv;
  assign eof_hit   = (state == S_DATA) && !eth_rx_dv;
  assign len_inc   = (len == 11'h7FF) ? len : len + 11'd1;
  assign crc_good  = (crc == CRC_RESIDUE);
  // phase=1 at dv fall means an odd nibble count; the dangling nibble never reached the CRC.
  assign frame_bad = !crc_good || phase || phy_err || too_long || (len < MIN_LEN);

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (cur_byte),
    .crc_next (crc_nxt)
  );

  always_ff @(posedge eth_rx_clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (eth_rx_dv) state_nxt = (eth_rx_d == PREAMBLE_NIBBLE) ? S_PREAMBLE : S_DROP;
      S_PREAMBLE:
        if (!eth_rx_dv)                      state_nxt = S_IDLE;
        else if (eth_rx_d == SFD_NIBBLE)     state_nxt = S_DATA;
        else if (eth_rx_d != PREAMBLE_NIBBLE) state_nxt = S_DROP;
      S_DATA:  if (!eth_rx_dv) state_nxt = S_IDLE;
      S_DROP:  if (!eth_rx_dv) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge eth_rx_clk or negedge rstn) begin
    if (!rstn) begin
      phase         <= 1'b0;
      low_nib       <= '0;
      crc           <= '0;
      len           <= '0;
      phy_err       <= 1'b0;
      too_long      <= 1'b0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_crc_ok     <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_len        <= '0;
    end else begin
      rx_byte_valid <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      if (sfd_hit) begin
        phase    <= 1'b0;
        crc      <= CRC_INIT;
        len      <= '0;
        phy_err  <= 1'b0;
        too_long <= 1'b0;
      end
      if (data_nib) begin
        if (eth_rx_err) phy_err <= 1'b1;
        if (!phase) begin
          low_nib <= eth_rx_d;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
          crc   <= crc_nxt;
          len   <= len_inc;
          // Oversize bytes still feed CRC and length, but are not presented downstream.
          if (len < MAX_LEN) begin
            rx_byte       <= cur_byte;
            rx_byte_valid <= 1'b1;
            rx_sof        <= (len == 11'd0);
          end else begin
            too_long <= 1'b1;
          end
        end
      end
      if (eof_hit) begin
        rx_eof       <= 1'b1;
        rx_crc_ok    <= crc_good;
        rx_frame_err <= frame_bad;
        rx_len       <= len;
      end
    end
  end

`ifdef MII_RX_STATS_EN
  always_ff @(posedge eth_rx_clk or negedge rstn) begin
    if (!rstn) begin
      frame_count   <= '0;
      crc_err_count <= '0;
    end else if (eof_hit) begin
      if (!frame_bad) frame_count   <= frame_count + 16'd1;
      if (!crc_good)  crc_err_count <= crc_err_count + 16'd1;
    end
  end
`else
  assign frame_count   = '0;
  assign crc_err_count = '0;
`endif
endmodule

// File: tb/tb_mii_rx_frame.sv
// Randomized self-checking bench for mii_rx_frame against a byte-level frame model.
`timescale 1ns/1ps
module tb_mii_rx_frame;
  logic        eth_rx_clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  eth_rx_d = '0;
  logic        eth_rx_dv = 1'b0;
  logic        eth_rx_err = 1'b0;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid, rx_sof, rx_eof, rx_crc_ok, rx_frame_err;
  logic [10:0] rx_len;
  logic [15:0] frame_count, crc_err_count;

  mii_rx_frame dut (
    .eth_rx_clk(eth_rx_clk), .rstn(rstn), .eth_rx_d(eth_rx_d), .eth_rx_dv(eth_rx_dv),
    .eth_rx_err(eth_rx_err), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_crc_ok(rx_crc_ok), .rx_frame_err(rx_frame_err),
    .rx_len(rx_len), .frame_count(frame_count), .crc_err_count(crc_err_count)
  );

  always #5 eth_rx_clk = ~eth_rx_clk;

  int passes = 0, checks = 0;

  // Frame under test and the monitor's view of the DUT.
  logic [7:0]  fr [0:2047];
  int          fr_n;
  logic [7:0]  got_q [$];
  int          sof_cnt, sof_pos, eof_cnt, overlap;
  logic        m_ok, m_err;
  logic [10:0] m_len;

  // Reference expectations.
  int          exp_n, exp_len;
  logic        exp_ok, exp_err;
  logic [15:0] exp_fc = 0, exp_cec = 0;

  always @(negedge eth_rx_clk) begin
    if (rx_byte_valid) got_q.push_back(rx_byte);
    if (rx_sof) begin sof_cnt++; sof_pos = got_q.size(); end
    if (rx_eof) begin eof_cnt++; m_ok = rx_crc_ok; m_err = rx_frame_err; m_len = rx_len; end
    if (rx_eof && rx_byte_valid) overlap++;
  end

  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Random payload followed by its FCS, complement of the CRC, low byte first.
  function automatic void build_frame(input int n);
    logic [31:0] f;
    for (int i = 0; i < n; i++) fr[i] = 8'($urandom_range(0, 255));
    f = ~crc_of(n);
    for (int k = 0; k < 4; k++) fr[n + k] = f[8*k +: 8];
    fr_n = n + 4;
  endfunction

  function automatic int bytes_bad();
    int bad = 0;
    for (int i = 0; i < exp_n; i++)
      if (i >= got_q.size() || got_q[i] !== fr[i]) bad++;
    return bad;
  endfunction

  // A frame is good iff the trailing four bytes equal the complemented CRC of the rest.
  function automatic void model(input bit odd, input bit perr);
    int n = fr_n;
    exp_n   = (n > 1518) ? 1518 : n;
    exp_len = (n > 2047) ? 2047 : n;
    exp_ok  = (crc_of(n - 4) == ~{fr[n-1], fr[n-2], fr[n-3], fr[n-4]});
    exp_err = !exp_ok || odd || perr || (n < 64) || (n > 1518);
`ifdef MII_RX_STATS_EN
    if (!exp_err) exp_fc++;
    if (!exp_ok)  exp_cec++;
`endif
  endfunction

  task automatic clr();
    got_q.delete(); sof_cnt = 0; sof_pos = 0; eof_cnt = 0; overlap = 0;
    m_ok = 1'bx; m_err = 1'bx; m_len = 'x;
  endtask

  task automatic nib(input logic [3:0] d, input logic dv, input logic er);
    eth_rx_d = d; eth_rx_dv = dv; eth_rx_err = er;
    @(posedge eth_rx_clk); #1;
  endtask

  task automatic send(input bit odd, input int err_at, input int gap);
    repeat (15) nib(4'h5, 1'b1, 1'b0);
    nib(4'hD, 1'b1, 1'b0);
    for (int i = 0; i < fr_n; i++) begin
      nib(fr[i][3:0], 1'b1, i == err_at);
      nib(fr[i][7:4], 1'b1, i == err_at);
    end
    if (odd) nib(4'hA, 1'b1, 1'b0);
    repeat (gap) nib(4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge eth_rx_clk);
    @(negedge eth_rx_clk);
    checks++;
    if ({rx_byte, rx_byte_valid, rx_sof, rx_eof, rx_crc_ok, rx_frame_err, rx_len,
         frame_count, crc_err_count} !== '0) $display("FAIL reset_outputs got nonzero exp 0");
    else passes++;
    @(posedge eth_rx_clk); #1; rstn = 1'b1;
    repeat (2) nib(4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_good();
    build_frame(60); clr(); send(0, -1, 4); model(0, 0);
    checks++; if (got_q.size() !== exp_n) $display("FAIL good_strobes got %0d exp %0d", got_q.size(), exp_n); else passes++;
    checks++; if (bytes_bad() !== 0) $display("FAIL good_bytes got %0d bad exp 0", bytes_bad()); else passes++;
    checks++; if (sof_cnt !== 1 || sof_pos !== 1) $display("FAIL good_sof got %0d@%0d exp 1@1", sof_cnt, sof_pos); else passes++;
    checks++; if (eof_cnt !== 1) $display("FAIL good_eof got %0d exp 1", eof_cnt); else passes++;
    checks++; if (m_ok !== exp_ok || m_err !== exp_err) $display("FAIL good_status got %b%b exp %b%b", m_ok, m_err, exp_ok, exp_err); else passes++;
    checks++; if (m_len !== 11'(exp_len)) $display("FAIL good_len got %0d exp %0d", m_len, exp_len); else passes++;
    checks++; if (overlap !== 0) $display("FAIL good_overlap got %0d exp 0", overlap); else passes++;
    checks++; if (frame_count !== exp_fc || crc_err_count !== exp_cec) $display("FAIL good_counters got %0d/%0d exp %0d/%0d", frame_count, crc_err_count, exp_fc, exp_cec); else passes++;
  endtask

  task automatic test_bad_fcs();
    fr[63] = fr[63] ^ 8'h01; clr(); send(0, -1, 4); model(0, 0);
    checks++; if (m_ok !== 1'b0 || m_ok !== exp_ok) $display("FAIL badfcs_ok got %b exp %b", m_ok, exp_ok); else passes++;
    checks++; if (m_err !== exp_err) $display("FAIL badfcs_err got %b exp %b", m_err, exp_err); else passes++;
    checks++; if (frame_count !== exp_fc || crc_err_count !== exp_cec) $display("FAIL badfcs_counters got %0d/%0d exp %0d/%0d", frame_count, crc_err_count, exp_fc, exp_cec); else passes++;
  endtask

  task automatic test_odd_nibble();
    build_frame(60); clr(); send(1, -1, 4); model(1, 0);
    checks++; if (got_q.size() !== 64 || bytes_bad() !== 0) $display("FAIL odd_bytes got %0d exp 64", got_q.size()); else passes++;
    checks++; if (m_err !== exp_err || m_ok !== exp_ok) $display("FAIL odd_status got %b%b exp %b%b", m_ok, m_err, exp_ok, exp_err); else passes++;
    checks++; if (m_len !== 11'd64) $display("FAIL odd_len got %0d exp 64", m_len); else passes++;
  endtask

  task automatic test_phy_err();
    build_frame(96); clr(); send(0, 20, 4); model(0, 1);
    checks++; if (got_q.size() !== exp_n || bytes_bad() !== 0) $display("FAIL phyerr_bytes got %0d exp %0d", got_q.size(), exp_n); else passes++;
    checks++; if (m_err !== exp_err || m_ok !== exp_ok) $display("FAIL phyerr_status got %b%b exp %b%b", m_ok, m_err, exp_ok, exp_err); else passes++;
  endtask

  task automatic test_length();
    build_frame(56); clr(); send(0, -1, 4); model(0, 0);
    checks++; if (m_err !== exp_err || m_ok !== exp_ok || m_len !== 11'(exp_len)) $display("FAIL short_status got %b%b/%0d exp %b%b/%0d", m_ok, m_err, m_len, exp_ok, exp_err, exp_len); else passes++;
    build_frame(1596); clr(); send(0, -1, 4); model(0, 0);
    checks++; if (got_q.size() !== 1518 || bytes_bad() !== 0) $display("FAIL long_strobes got %0d exp 1518", got_q.size()); else passes++;
    checks++; if (m_err !== exp_err || m_ok !== exp_ok || m_len !== 11'd1600) $display("FAIL long_status got %b%b/%0d exp %b%b/1600", m_ok, m_err, m_len, exp_ok, exp_err); else passes++;
    checks++; if (frame_count !== exp_fc || crc_err_count !== exp_cec) $display("FAIL long_counters got %0d/%0d exp %0d/%0d", frame_count, crc_err_count, exp_fc, exp_cec); else passes++;
  endtask

  task automatic test_drop();
    clr();
    nib(4'h3, 1'b1, 1'b0);
    repeat (14) nib(4'h5, 1'b1, 1'b0);
    nib(4'hD, 1'b1, 1'b0);
    repeat (80) nib(4'($urandom_range(0, 15)), 1'b1, 1'b0);
    repeat (4) nib(4'h0, 1'b0, 1'b0);
    checks++; if (got_q.size() !== 0 || eof_cnt !== 0) $display("FAIL drop_silent got %0d bytes %0d eof exp 0", got_q.size(), eof_cnt); else passes++;
    build_frame(70); clr(); send(0, -1, 4); model(0, 0);
    checks++; if (eof_cnt !== 1 || m_ok !== exp_ok || m_err !== exp_err || bytes_bad() !== 0) $display("FAIL drop_next got eof %0d %b%b exp 1 %b%b", eof_cnt, m_ok, m_err, exp_ok, exp_err); else passes++;
  endtask

  task automatic test_reset_mid();
    build_frame(60); clr();
    repeat (15) nib(4'h5, 1'b1, 1'b0);
    nib(4'hD, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin nib(fr[i][3:0], 1'b1, 1'b0); nib(fr[i][7:4], 1'b1, 1'b0); end
    rstn = 1'b0; eth_rx_dv = 1'b0;
    exp_fc = 0; exp_cec = 0;
    @(negedge eth_rx_clk);
    checks++;
    if ({rx_byte, rx_byte_valid, rx_sof, rx_eof, rx_crc_ok, rx_frame_err, rx_len,
         frame_count, crc_err_count} !== '0) $display("FAIL midreset_outputs got nonzero exp 0");
    else passes++;
    @(posedge eth_rx_clk); #1; rstn = 1'b1;
    repeat (4) nib(4'h0, 1'b0, 1'b0);
    checks++; if (eof_cnt !== 0) $display("FAIL midreset_eof got %0d exp 0", eof_cnt); else passes++;
    clr(); send(0, -1, 4); model(0, 0);
    checks++; if (m_ok !== exp_ok || m_err !== exp_err || m_len !== 11'd64 || bytes_bad() !== 0) $display("FAIL midreset_next got %b%b/%0d exp %b%b/64", m_ok, m_err, m_len, exp_ok, exp_err); else passes++;
    checks++; if (frame_count !== exp_fc) $display("FAIL midreset_count got %0d exp %0d", frame_count, exp_fc); else passes++;
  endtask

  task automatic test_back_to_back();
    build_frame(60); clr();
    send(0, -1, 1); model(0, 0);
    send(0, -1, 4); model(0, 0);
    checks++; if (eof_cnt !== 2 || sof_cnt !== 2 || got_q.size() !== 128) $display("FAIL b2b_frames got eof %0d sof %0d bytes %0d exp 2 2 128", eof_cnt, sof_cnt, got_q.size()); else passes++;
    checks++; if (m_ok !== exp_ok || m_err !== exp_err || frame_count !== exp_fc) $display("FAIL b2b_status got %b%b/%0d exp %b%b/%0d", m_ok, m_err, frame_count, exp_ok, exp_err, exp_fc); else passes++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      bit odd, corrupt, perr;
      int ea;
      build_frame($urandom_range(50, 300));
      corrupt = ($urandom_range(0, 2) == 0);
      odd     = ($urandom_range(0, 3) == 0);
      perr    = ($urandom_range(0, 3) == 0);
      if (corrupt) begin ea = $urandom_range(0, fr_n - 1); fr[ea] = fr[ea] ^ 8'(1 << $urandom_range(0, 7)); end
      clr(); send(odd, perr ? int'($urandom_range(0, fr_n - 1)) : -1, 3); model(odd, perr);
      checks++;
      if (m_ok !== exp_ok || m_err !== exp_err || m_len !== 11'(exp_len) || got_q.size() !== exp_n || bytes_bad() !== 0 || overlap !== 0)
        $display("FAIL rand%0d got %b%b/%0d/%0d exp %b%b/%0d/%0d", t, m_ok, m_err, m_len, got_q.size(), exp_ok, exp_err, exp_len, exp_n);
      else passes++;
    end
    checks++; if (frame_count !== exp_fc || crc_err_count !== exp_cec) $display("FAIL rand_counters got %0d/%0d exp %0d/%0d", frame_count, crc_err_count, exp_fc, exp_cec); else passes++;
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_fcs();
    test_odd_nibble();
    test_phy_err();
    test_length();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mii_rx_frame.md
# mii_rx_frame

MII receive-side frame decoder for the Arty Ethernet test design, the counterpart of the MII transmit path. It samples the PHY's 4-bit receive nibbles on `eth_rx_clk`, strips the preamble and SFD, and reassembles bytes. It checks FCS (CRC-32), length and alignment, and reports per-frame status plus optional frame and error counters to downstream logic in the same clock domain.

## Interface
- `MIN_FRAME_BYTES`, 64, minimum legal frame length (DA through FCS); shorter frames flagged
- `MAX_FRAME_BYTES`, 1518, maximum legal frame length; longer frames flagged, excess bytes not output
- `eth_rx_clk`  in  1  PHY receive clock (25 MHz at 100 Mb/s); the only clock
- `rstn`  in  1  asynchronous active-low reset
- `eth_rx_d`  in  4  receive nibble from PHY, low nibble of each byte first
- `eth_rx_dv`  in  1  receive data valid
- `eth_rx_err`  in  1  PHY receive error
- `rx_byte`  out  8  reassembled frame byte (DA through FCS inclusive)
- `rx_byte_valid`  out  1  one-cycle strobe, `rx_byte` valid
- `rx_sof`  out  1  high with the first `rx_byte_valid` of a frame
- `rx_eof`  out  1  one-cycle end-of-frame strobe; status outputs valid in this cycle
- `rx_crc_ok`  out  1  FCS residue correct (qualified by `rx_eof`)
- `rx_frame_err`  out  1  any of: CRC bad, odd nibble count, PHY error, short, long (qualified by `rx_eof`)
- `rx_len`  out  11  frame byte count, saturating at 2047 (qualified by `rx_eof`)
- `frame_count`  out  16  frames with `rx_frame_err`=0, wrapping
- `crc_err_count`  out  16  frames with `rx_crc_ok`=0, wrapping

## Operation
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE: `eth_rx_dv`=1 and nibble 0x5 -> PREAMBLE. Any other nibble with dv=1 -> DROP.
- PREAMBLE: nibble 0x5 stays. Nibble 0xD -> DATA with nibble phase 0, CRC=0xFFFFFFFF, length=0. Other nibble -> DROP. dv=0 -> IDLE with no `rx_eof`.
- DATA, phase 0: latch the nibble as the low half. Phase 1: form the byte {nibble, low}, update the CRC and the length.
- Bytes are emitted only while length < `MAX_FRAME_BYTES`. Beyond that, the frame is marked too-long and bytes are suppressed.
- `eth_rx_err`=1 in DATA sets a sticky error flag; bytes keep flowing.
- DATA with dv sampled 0 -> IDLE and assert `rx_eof` with the status fields.
- Alignment error: phase was 1 (odd nibble count) when dv fell. The dangling nibble is discarded.
- DROP: ignore everything until dv=0, then IDLE. No output.
- CRC: reflected polynomial 0xEDB88320, byte-wise, LSB first, applied over all bytes including FCS, no final XOR. `rx_crc_ok` = (register == 0xDEBB20E3).
- Counters update in the `rx_eof` cycle. Both may increment on the same frame.

## Timing
- All outputs reset to 0. State resets to IDLE. Reset mid-frame abandons the frame silently, with no `rx_eof`.
- `rx_byte_valid` rises one cycle after the phase-1 nibble is sampled. Bytes are at most one every 2 cycles.
- `rx_eof` rises one cycle after dv is sampled low. It is never coincident with `rx_byte_valid`.
- dv re-asserted the cycle after falling starts a new preamble normally. The IFG is not checked.
- `rx_len` counts all frame bytes, suppressed ones included, saturating at 2047.

## Configuration
- `MII_RX_STATS_EN` defined: `frame_count` and `crc_err_count` are implemented.
- Not defined: both ports are driven constant 0 and no counter flops exist. All other behaviour is identical.

## Structure
- Package `mii_rx_pkg`: state enum, `PREAMBLE_NIBBLE`=4'h5, `SFD_NIBBLE`=4'hD, `CRC_INIT`=32'hFFFFFFFF, `CRC_POLY`=32'hEDB88320, `CRC_RESIDUE`=32'hDEBB20E3.
- Sub-module `crc32_d8`: combinational next-CRC from the current CRC and one byte. It is reused by the TX-side FCS generator.

## Test plan
- 15×0x5, 0xD, then a 64-byte frame with correct FCS -> 64 `rx_byte_valid` strobes, `rx_sof` on the first, `rx_eof` with `rx_crc_ok`=1, `rx_frame_err`=0, `rx_len`=64, `frame_count`=1.
- Same frame with the last FCS byte XOR 0x01 -> `rx_crc_ok`=0, `rx_frame_err`=1, `crc_err_count`=1, `frame_count` unchanged.
- Good frame plus one extra nibble before dv falls -> 64 bytes output, `rx_frame_err`=1, `rx_len`=64.
- `eth_rx_err` pulsed during byte 20 -> all bytes output, `rx_frame_err`=1, `rx_crc_ok` reflects the data.
- Frames of 60 and 1600 bytes with valid FCS -> both flagged. The 1600-byte frame shows exactly 1518 strobes and `rx_len`=1600.
- Preamble starting with nibble 0x3, then a good frame after dv low -> first frame dropped silently, second received. Separately, `rstn` pulsed mid-frame -> no `rx_eof`, all outputs 0, next frame received correctly.
